// File: rtl/fibo_scroller.sv
// Fibonacci table generator feeding a two-row LCD text scroller.
// Fills a DEPTH-entry term table after reset, then steps through adjacent pairs once per TICK cycles.
module fibo_scroller #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 25,
  parameter int unsigned TICK  = 75000000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     btn_dir,
  input  logic                     btn_pause,
  output logic [127:0]             row_A,
  output logic [127:0]             row_B,
  output logic                     busy,
  output logic                     ovf,
  output logic [$clog2(DEPTH)-1:0] cur_idx
);

  localparam int unsigned IdxW   = $clog2(DEPTH);
  localparam int unsigned TickW  = $clog2(TICK);
  localparam int unsigned Digits = WIDTH / 4;

  localparam logic [127:0] IdleA = "Press BTN3 to   ";
  localparam logic [127:0] IdleB = "show a message..";

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  // Term table and fill sequencer
  logic [WIDTH-1:0] term_q [DEPTH];
  logic [DEPTH-1:0] term_ovf_q;
  logic [IdxW-1:0]  fill_q;
  logic [IdxW-1:0]  src1, src2;
  logic [WIDTH:0]   sum;
  logic             sum_ovf;
  logic             busy_q, ovf_q;

  always_comb begin
    src1    = fill_q - IdxW'(1);
    src2    = fill_q - IdxW'(2);
    sum     = {1'b0, term_q[src1]} + {1'b0, term_q[src2]};
    sum_ovf = sum[WIDTH] | term_ovf_q[src1] | term_ovf_q[src2];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      term_q[0]  <= '0;
      term_q[1]  <= WIDTH'(1);
      term_ovf_q <= '0;
      fill_q     <= IdxW'(2);
      busy_q     <= 1'b1;
      ovf_q      <= 1'b0;
    end else if (busy_q) begin
      term_q[fill_q]     <= sum[WIDTH-1:0];
      term_ovf_q[fill_q] <= sum_ovf;
      ovf_q              <= ovf_q | sum_ovf;
      if (fill_q == IdxW'(DEPTH - 1)) begin
        busy_q <= 1'b0;
      end else begin
        fill_q <= fill_q + IdxW'(1);
      end
    end
  end

  // One LCD row: "#NN " followed by a 12-char right-justified hex field.
  function automatic logic [127:0] fmt_row(input logic [IdxW-1:0] k,
                                           input logic [WIDTH-1:0] val,
                                           input logic bad);
    logic [127:0] r;
    int unsigned  num;
    logic [3:0]   nib;
    r          = {16{8'h20}};
    num        = 32'(k) + 32'd1;
    r[127:120] = 8'h23;
    r[119:112] = 8'h30 + 8'(num / 10);
    r[111:104] = 8'h30 + 8'(num % 10);
    for (int d = 0; d < int'(Digits); d++) begin
      nib = 4'(val >> (4 * (int'(Digits) - 1 - d)));
      r[8*(int'(Digits)-1-d) +: 8] = bad ? 8'h2d :
          (nib < 4'd10) ? 8'h30 + {4'h0, nib} : 8'h37 + {4'h0, nib};
    end
    return r;
  endfunction

  // Control FSM, tick counter and display registers
  state_e           state_q, state_d;
  logic             dir_q, dir_d;  // 1 = reverse
  logic [TickW-1:0] tick_q;
  logic [IdxW-1:0]  idx_q, idx_d, idx_hi;
  logic [127:0]     row_a_q, row_b_q, row_lo, row_hi;
  logic             tick_last, step;

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    case (state_q)
      StIdle: begin
        if (btn_dir) begin
          state_d = StRun;
          dir_d   = 1'b0;
        end
      end
      StRun: begin
        if (btn_pause) state_d = StPause;
        if (btn_dir)   dir_d   = ~dir_q;
      end
      StPause: begin
        if (btn_pause) state_d = StRun;
        if (btn_dir)   dir_d   = ~dir_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tick_last = (tick_q == TickW'(TICK - 1));
    // Any button pulse on the step cycle suppresses that step.
    step      = tick_last && (state_q == StRun) && !busy_q && !btn_dir && !btn_pause;
    idx_hi    = idx_q + IdxW'(1);
    row_lo    = fmt_row(idx_q, term_q[idx_q], term_ovf_q[idx_q]);
    row_hi    = fmt_row(idx_hi, term_q[idx_hi], term_ovf_q[idx_hi]);
    if (dir_q) begin
      idx_d = (idx_q == '0) ? IdxW'(DEPTH - 2) : idx_q - IdxW'(1);
    end else begin
      idx_d = (idx_q == IdxW'(DEPTH - 2)) ? '0 : idx_hi;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      dir_q   <= 1'b0;
      tick_q  <= '0;
      idx_q   <= '0;
      row_a_q <= IdleA;
      row_b_q <= IdleB;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      tick_q  <= tick_last ? '0 : tick_q + TickW'(1);
      if (step) begin
        idx_q   <= idx_d;
        row_a_q <= dir_q ? row_hi : row_lo;
        row_b_q <= dir_q ? row_lo : row_hi;
      end
    end
  end

  assign row_A   = row_a_q;
  assign row_B   = row_b_q;
  assign busy    = busy_q;
  assign ovf     = ovf_q;
  assign cur_idx = idx_q;

endmodule

// File: tb/tb_fibo_scroller.sv
// Directed bench for fibo_scroller: fill, forward/reverse wrap, overflow display,
// pause, button/step collisions and mid-run reset, with TICK=4.
module tb_fibo_scroller;

  logic clk = 1'b0;
  logic reset, btn_dir, btn_pause;

  logic [127:0] row_a25, row_b25, row_a26, row_b26;
  logic         busy25, ovf25, busy26, ovf26;
  logic [4:0]   cur25, cur26;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] IdleA = "Press BTN3 to   ";
  localparam logic [127:0] IdleB = "show a message..";
  localparam logic [127:0] R01   = "#01         0000";
  localparam logic [127:0] R02   = "#02         0001";
  localparam logic [127:0] R03   = "#03         0001";
  localparam logic [127:0] R23   = "#23         452F";
  localparam logic [127:0] R24   = "#24         6FF1";
  localparam logic [127:0] R25   = "#25         B520";
  localparam logic [127:0] R26o  = "#26         ----";

  fibo_scroller #(.WIDTH(16), .DEPTH(25), .TICK(4)) u_dut25 (
    .clk       (clk),
    .reset     (reset),
    .btn_dir   (btn_dir),
    .btn_pause (btn_pause),
    .row_A     (row_a25),
    .row_B     (row_b25),
    .busy      (busy25),
    .ovf       (ovf25),
    .cur_idx   (cur25)
  );

  fibo_scroller #(.WIDTH(16), .DEPTH(26), .TICK(4)) u_dut26 (
    .clk       (clk),
    .reset     (reset),
    .btn_dir   (btn_dir),
    .btn_pause (btn_pause),
    .row_A     (row_a26),
    .row_B     (row_b26),
    .busy      (busy26),
    .ovf       (ovf26),
    .cur_idx   (cur26)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic d, input logic p);
    btn_dir   = d;
    btn_pause = p;
    cyc();
    btn_dir   = 1'b0;
    btn_pause = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    btn_dir   = 1'b0;
    btn_pause = 1'b0;
    repeat (3) cyc();
    check_eq("rst_row_a", row_a25, IdleA);
    check_eq("rst_row_b", row_b25, IdleB);
    check_eq("rst_busy", 128'(busy25), 128'(1));
    check_eq("rst_ovf", 128'(ovf25), 128'(0));
    check_eq("rst_idx", 128'(cur25), 128'(0));
    reset = 1'b0;

    // Fill: busy low 23 cycles after release for DEPTH=25, 24 for DEPTH=26
    repeat (22) cyc();
    check_eq("busy_n22", 128'(busy25), 128'(1));
    cyc();
    check_eq("busy_n23", 128'(busy25), 128'(0));
    check_eq("ovf25", 128'(ovf25), 128'(0));
    check_eq("busy26_n23", 128'(busy26), 128'(1));
    cyc();
    check_eq("busy26_n24", 128'(busy26), 128'(0));
    check_eq("ovf26", 128'(ovf26), 128'(1));

    // Start at n=25; first step commits at n=28
    pulse(1'b1, 1'b0);
    repeat (2) cyc();
    check_eq("hold_idle_a", row_a25, IdleA);
    check_eq("hold_idle_idx", 128'(cur25), 128'(0));
    cyc();
    check_eq("s1_row_a", row_a25, R01);
    check_eq("s1_row_b", row_b25, R02);
    check_eq("s1_idx", 128'(cur25), 128'(1));

    for (int s = 2; s <= 23; s++) begin
      repeat (4) cyc();
      check_eq("fwd_idx", 128'(cur25), 128'(s));
    end
    repeat (4) cyc();
    check_eq("s24_row_a", row_a25, R24);
    check_eq("s24_row_b", row_b25, R25);
    check_eq("s24_idx", 128'(cur25), 128'(0));
    repeat (4) cyc();
    check_eq("s25_row_a", row_a25, R01);
    check_eq("s25_row_b", row_b25, R02);
    check_eq("s25_idx", 128'(cur25), 128'(1));
    check_eq("ovf_row_a", row_a26, R25);
    check_eq("ovf_row_b", row_b26, R26o);
    check_eq("ovf_idx", 128'(cur26), 128'(0));

    // Reverse from i=1 (n=125), steps at n=128 and n=132
    pulse(1'b1, 1'b0);
    repeat (3) cyc();
    check_eq("rev1_row_a", row_a25, R03);
    check_eq("rev1_row_b", row_b25, R02);
    check_eq("rev1_idx", 128'(cur25), 128'(0));
    repeat (4) cyc();
    check_eq("rev2_row_a", row_a25, R02);
    check_eq("rev2_row_b", row_b25, R01);
    check_eq("rev2_idx", 128'(cur25), 128'(23));

    // Pause for 3 tick periods, resume on the counter's last cycle
    pulse(1'b0, 1'b1);
    repeat (12) cyc();
    check_eq("pause_row_a", row_a25, R02);
    check_eq("pause_idx", 128'(cur25), 128'(23));
    repeat (2) cyc();
    pulse(1'b0, 1'b1);
    check_eq("resume_nostep", 128'(cur25), 128'(23));
    repeat (3) cyc();
    check_eq("resume_wait", 128'(cur25), 128'(23));
    cyc();
    check_eq("resume_row_a", row_a25, R25);
    check_eq("resume_row_b", row_b25, R24);
    check_eq("resume_idx", 128'(cur25), 128'(22));

    // Direction pulse on a step cycle in RUN drops that step
    repeat (3) cyc();
    pulse(1'b1, 1'b0);
    check_eq("coll_idx", 128'(cur25), 128'(22));
    repeat (4) cyc();
    check_eq("coll_row_a", row_a25, R23);
    check_eq("coll_row_b", row_b25, R24);
    check_eq("coll_idx2", 128'(cur25), 128'(23));

    // Both buttons together: pause and reverse
    pulse(1'b1, 1'b1);
    repeat (7) cyc();
    check_eq("both_hold", 128'(cur25), 128'(23));
    pulse(1'b0, 1'b1);
    repeat (3) cyc();
    check_eq("both_row_a", row_a25, R25);
    check_eq("both_row_b", row_b25, R24);
    check_eq("both_idx", 128'(cur25), 128'(22));

    // Mid-run reset, restart during fill; ticks while busy are dropped
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_eq("mrst_row_a", row_a25, IdleA);
    check_eq("mrst_row_b", row_b25, IdleB);
    check_eq("mrst_busy", 128'(busy25), 128'(1));
    check_eq("mrst_idx", 128'(cur25), 128'(0));
    pulse(1'b1, 1'b0);
    repeat (21) cyc();
    check_eq("fill_nostep_idx", 128'(cur25), 128'(0));
    check_eq("fill_nostep_row", row_a25, IdleA);
    cyc();
    check_eq("fill_done_busy", 128'(busy25), 128'(0));
    check_eq("fill_done_idx", 128'(cur25), 128'(0));
    cyc();
    check_eq("restart_row_a", row_a25, R01);
    check_eq("restart_row_b", row_b25, R02);
    check_eq("restart_idx", 128'(cur25), 128'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
